// File: rtl/comp_input_packer.sv
// Byte-stream packer: gathers up-to-LANES-byte input beats into STRINGSIZE-byte
// blocks for the compressor, splitting beats that straddle a block boundary.
module comp_input_packer #(
    parameter int STRINGSIZE = 88,
    parameter int LANES      = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [LANES-1:0][7:0]                  in_data,
    input  logic [$clog2(LANES+1)-1:0]             in_count,
    input  logic                                   in_last,
    output logic                                   blk_valid,
    input  logic                                   blk_ready,
    output logic [STRINGSIZE-1:0][7:0]             blk_data,
    output logic [$clog2(STRINGSIZE+1)-1:0]        blk_len,
    output logic                                   blk_last,
    output logic                                   err
);

    localparam int CW    = $clog2(LANES + 1);
    localparam int LW    = $clog2(STRINGSIZE + 1);
    localparam int SPW   = (LANES > 1) ? LANES - 1 : 1;
    localparam int BUFW  = STRINGSIZE * 8;
    localparam int LANEW = LANES * 8;
    localparam int SPB   = SPW * 8;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [BUFW-1:0]  buf_q, buf_d;
    logic [LW-1:0]    fill_q, fill_d;
    logic [SPB-1:0]   spill_q, spill_d;
    logic [CW-1:0]    spill_n_q, spill_n_d;
    logic             spill_last_q, spill_last_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic             accept;
    logic             consume;
    int               beat_n;
    int               fill_int;
    int               total;
    logic [LANEW-1:0] beat_m;
    logic [BUFW-1:0]  beat_sh;
    logic [SPB-1:0]   beat_tail;

    function automatic int clamp_count(input logic [CW-1:0] c);
        int ci;
        ci = int'(c);
        return (ci > LANES) ? LANES : ci;
    endfunction

    // Zero every lane at or above n so stray bytes never reach the buffer.
    function automatic logic [LANEW-1:0] mask_lanes(input logic [LANEW-1:0] d, input int n);
        logic [LANEW-1:0] m;
        m = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < n) m[k*8 +: 8] = d[k*8 +: 8];
        end
        return m;
    endfunction

    assign in_ready  = (state_q == FILL) && !reset;
    assign blk_valid = (state_q == FLUSH);
    assign blk_data  = buf_q;
    assign blk_len   = fill_q;
    assign blk_last  = last_q;
    assign err       = err_q;

    assign accept  = in_valid && in_ready;
    assign consume = blk_valid && blk_ready;

    // Beat alignment: shift masked lanes up to the fill point; the part past
    // the block end drops off and is recovered as the spill tail.
    always_comb begin
        beat_n    = clamp_count(in_count);
        fill_int  = int'(fill_q);
        total     = fill_int + beat_n;
        beat_m    = mask_lanes(in_data, beat_n);
        beat_sh   = BUFW'(beat_m) << (fill_int * 8);
        beat_tail = SPB'(beat_m >> ((STRINGSIZE - fill_int) * 8));
    end

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        fill_d       = fill_q;
        spill_d      = spill_q;
        spill_n_d    = spill_n_q;
        spill_last_d = spill_last_q;
        last_d       = last_q;
        err_d        = err_q;

        if (state_q == FILL) begin
            if (accept) begin
                if (int'(in_count) > LANES) err_d = 1'b1;
                if (beat_n == 0 && !in_last) begin
                    state_d = FILL;
                end else if (total > STRINGSIZE) begin
                    buf_d        = buf_q | beat_sh;
                    spill_d      = beat_tail;
                    spill_n_d    = CW'(total - STRINGSIZE);
                    spill_last_d = in_last;
                    fill_d       = LW'(STRINGSIZE);
                    last_d       = 1'b0;
                    state_d      = FLUSH;
                end else if (total == STRINGSIZE || in_last) begin
                    buf_d   = buf_q | beat_sh;
                    fill_d  = LW'(total);
                    last_d  = in_last;
                    state_d = FLUSH;
                end else begin
                    buf_d  = buf_q | beat_sh;
                    fill_d = LW'(total);
                end
            end
        end else begin
            if (consume) begin
                if (spill_n_q != '0) begin
                    buf_d        = BUFW'(spill_q);
                    fill_d       = LW'(spill_n_q);
                    spill_d      = '0;
                    spill_n_d    = '0;
                    spill_last_d = 1'b0;
                    // A final tail goes out as its own block with no idle cycle.
                    if (spill_last_q) begin
                        last_d  = 1'b1;
                        state_d = FLUSH;
                    end else begin
                        last_d  = 1'b0;
                        state_d = FILL;
                    end
                end else begin
                    buf_d   = '0;
                    fill_d  = '0;
                    last_d  = 1'b0;
                    state_d = FILL;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= FILL;
            buf_q        <= '0;
            fill_q       <= '0;
            spill_q      <= '0;
            spill_n_q    <= '0;
            spill_last_q <= 1'b0;
            last_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            fill_q       <= fill_d;
            spill_q      <= spill_d;
            spill_n_q    <= spill_n_d;
            spill_last_q <= spill_last_d;
            last_q       <= last_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_comp_input_packer.sv
// Bench for comp_input_packer: directed scenarios plus random beats, checked
// against a byte-queue model that chops the stream into blocks.
module tb_comp_input_packer;

    localparam int SS = 88;
    localparam int LN = 16;
    localparam int CW = $clog2(LN + 1);
    localparam int LW = $clog2(SS + 1);

    typedef struct {
        int             len;
        logic           last;
        logic [SS*8-1:0] data;
    } blk_t;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [LN-1:0][7:0]    in_data;
    logic [CW-1:0]         in_count;
    logic                  in_last;
    logic                  blk_valid;
    logic                  blk_ready;
    logic [SS-1:0][7:0]    blk_data;
    logic [LW-1:0]         blk_len;
    logic                  blk_last;
    logic                  err;

    always #5 clock = ~clock;

    comp_input_packer #(.STRINGSIZE(SS), .LANES(LN)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_len   (blk_len),
        .blk_last  (blk_last),
        .err       (err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  pend[$];
    blk_t        expq[$];
    logic        err_exp = 1'b0;
    int          got_len[$];
    logic        got_last[$];

    task automatic chk(input string tag, input logic [SS*8-1:0] got, input logic [SS*8-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void emit(input int len, input logic last);
        blk_t b;
        b.len  = len;
        b.last = last;
        b.data = '0;
        for (int i = 0; i < len; i++) b.data[i*8 +: 8] = pend.pop_front();
        expq.push_back(b);
    endfunction

    // Stream model: append accepted bytes, cut full blocks while more data
    // follows, and flush whatever remains when the beat is the last one.
    function automatic void model_beat(input logic [LN*8-1:0] d, input int cnt, input logic last);
        int n;
        n = (cnt > LN) ? LN : cnt;
        if (cnt > LN) err_exp = 1'b1;
        for (int k = 0; k < n; k++) pend.push_back(d[k*8 +: 8]);
        while (pend.size() > SS || (pend.size() == SS && !last)) emit(SS, 1'b0);
        if (last) emit(pend.size(), 1'b1);
    endfunction

    task automatic step(input logic v, input int cnt, input logic last, input logic rdy,
                        input logic rst, output logic acc);
        logic [LN*8-1:0] d;
        logic            mvalid;
        for (int k = 0; k < LN; k++) d[k*8 +: 8] = 8'($urandom);
        in_valid  = v;
        in_count  = CW'(cnt);
        in_last   = last;
        in_data   = d;
        blk_ready = rdy;
        reset     = rst;
        #1;
        mvalid = (expq.size() != 0);
        chk("blk_valid", blk_valid, mvalid);
        chk("in_ready", in_ready, !mvalid && !rst);
        chk("err", err, err_exp);
        if (blk_valid && mvalid) begin
            chk("blk_len", blk_len, expq[0].len);
            chk("blk_last", blk_last, expq[0].last);
            chk("blk_data", blk_data, expq[0].data);
        end
        acc = !rst && v && !mvalid;
        if (rst) begin
            pend.delete();
            expq.delete();
            err_exp = 1'b0;
        end else if (mvalid && rdy) begin
            got_len.push_back(int'(blk_len));
            got_last.push_back(blk_last);
            expq.delete(0);
        end else if (acc) begin
            model_beat(d, cnt, last);
        end
        @(negedge clock);
    endtask

    task automatic send(input int cnt, input logic last, input logic rdy);
        logic acc;
        for (int t = 0; t < 50; t++) begin
            step(1'b1, cnt, last, rdy, 1'b0, acc);
            if (acc) return;
        end
        chk("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        for (int t = 0; t < n; t++) step(1'b0, 0, 1'b0, rdy, 1'b0, acc);
    endtask

    task automatic clear_got();
        got_len.delete();
        got_last.delete();
    endtask

    initial begin
        logic acc;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_count  = '0;
        in_last   = 1'b0;
        in_data   = '0;
        blk_ready = 1'b0;
        @(negedge clock);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_blk_valid", blk_valid, 1'b0);
        chk("rst_blk_data", blk_data, '0);
        chk("rst_blk_len", blk_len, 0);
        chk("rst_blk_last", blk_last, 1'b0);
        chk("rst_err", err, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1, acc);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, acc);

        // Exact fill: 5x16 + 8 with last.
        clear_got();
        for (int i = 0; i < 5; i++) send(16, 1'b0, 1'b1);
        send(8, 1'b1, 1'b1);
        idle(3, 1'b1);
        chk("exact_nblk", got_len.size(), 1);
        chk("exact_len", got_len[0], 88);
        chk("exact_last", got_last[0], 1'b1);

        // Split without last: 6x16 + 4 with last.
        clear_got();
        for (int i = 0; i < 6; i++) send(16, 1'b0, 1'b1);
        send(4, 1'b1, 1'b1);
        idle(3, 1'b1);
        chk("split_nblk", got_len.size(), 2);
        chk("split_len0", got_len[0], 88);
        chk("split_last0", got_last[0], 1'b0);
        chk("split_len1", got_len[1], 12);
        chk("split_last1", got_last[1], 1'b1);

        // Split with last: 5x16 + 10 with last, tail block back-to-back.
        clear_got();
        for (int i = 0; i < 5; i++) send(16, 1'b0, 1'b1);
        send(10, 1'b1, 1'b1);
        #1;
        chk("spl_first_valid", blk_valid, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, acc);
        #1;
        chk("spl_nogap_valid", blk_valid, 1'b1);
        chk("spl_nogap_len", blk_len, 2);
        idle(3, 1'b1);
        chk("spl_len0", got_len[0], 88);
        chk("spl_last0", got_last[0], 1'b0);
        chk("spl_len1", got_len[1], 2);
        chk("spl_last1", got_last[1], 1'b1);

        // Backpressure: block held for 10 cycles while extra beats are offered.
        clear_got();
        for (int i = 0; i < 5; i++) send(16, 1'b0, 1'b1);
        send(8, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 16, 1'b0, 1'b0, 1'b0, acc);
        chk("bp_held", got_len.size(), 0);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, acc);
        idle(2, 1'b1);
        chk("bp_nblk", got_len.size(), 1);
        chk("bp_len", got_len[0], 88);

        // Oversized count sets err; then an empty last beat from fill 0.
        clear_got();
        send(20, 1'b1, 1'b1);
        idle(2, 1'b1);
        chk("err_set", err, 1'b1);
        send(0, 1'b1, 1'b1);
        idle(2, 1'b1);
        chk("ovf_len", got_len[0], 16);
        chk("empty_len", got_len[1], 0);
        chk("empty_last", got_last[1], 1'b1);
        chk("err_sticky", err, 1'b1);

        // Reset while a block with an 8-byte spill is waiting.
        clear_got();
        for (int i = 0; i < 5; i++) send(16, 1'b0, 1'b1);
        send(16, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, acc);
        chk("rst_err_clr", err, 1'b0);
        send(16, 1'b1, 1'b1);
        idle(2, 1'b1);
        chk("rst_nblk", got_len.size(), 1);
        chk("rst_len", got_len[0], 16);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic v, last, rdy;
            int   cnt;
            v    = ($urandom_range(0, 3) != 0);
            cnt  = ($urandom_range(0, 19) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
            last = ($urandom_range(0, 9) == 0);
            rdy  = ($urandom_range(0, 9) < 7);
            step(v, cnt, last, rdy, 1'b0, acc);
        end
        send(0, 1'b1, 1'b1);
        for (int t = 0; t < 100 && expq.size() != 0; t++) idle(1, 1'b1);
        chk("drain", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
